lsu: RTL and testbench
======================

# lsu

Load/store unit in the execute→memory boundary of the pipeline. It consumes the ALU result as the effective address plus rs2 store data. It runs a request/grant/response handshake with data memory, handling byte/halfword lane alignment, and returns sign- or zero-extended load data to writeback. It raises misalignment, illegal-width and bus-timeout exceptions, and stalls the pipeline through `ex_ready` while a transaction is in flight.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ+WAIT before abort; range 1–255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ex_valid` in 1: execute stage presents an op.
- `ex_ready` out 1: LSU accepts the op this cycle.
- `ex_mem_read` / `ex_mem_write` in 1 each: load / store; both 0 = no-op, accepted and ignored; both 1 = illegal.
- `ex_funct3` in 3: RV32I width code.
- `ex_addr` in 32: ALU result = effective address.
- `ex_wdata` in 32: rs2 store data.
- `ex_rd` in 5: load destination.
- `mem_req` out 1: bus request.
- `mem_we` out 1: store.
- `mem_addr` out 32: word address, bits[1:0]=0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte enables (0 for loads).
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `wb_valid` out 1: one-cycle load result pulse.
- `wb_rd` out 5: load destination.
- `wb_data` out 32: extended load data.
- `store_done` out 1: one-cycle pulse on store grant.
- `exc_valid` out 1: one-cycle exception pulse.
- `exc_cause` out 2: 00 illegal width, 01 load misaligned, 10 store misaligned, 11 bus timeout.
- `exc_addr` out 32: faulting `ex_addr`.

## Operation
- States: IDLE, REQ, WAIT. `ex_ready` = (state==IDLE) && `rst_n`. Accept = `ex_valid` && `ex_ready`.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code, or read and write both set, is illegal: cause 00, no bus access.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Cause 01 (load) or 10 (store); no bus access; state stays IDLE.
- Legal aligned accept in IDLE:
  - Register addr, rd, funct3 and we. Go to REQ. Clear the timeout counter.
- REQ:
  - `mem_req`=1 with stable addr/we/wdata/wstrb until `mem_gnt`.
  - On gnt, a store pulses `store_done` next cycle and returns to IDLE.
  - On gnt, a load goes to WAIT.
- WAIT:
  - On `mem_rvalid`, compute `wb_data` and pulse `wb_valid` next cycle. Return to IDLE.
  - `mem_rvalid` in IDLE or REQ is ignored. The bus contract places rvalid no earlier than the cycle after gnt.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011<<addr[1:0].
  - SW: wdata unchanged, wstrb=1111.
- Load extraction: s = rdata >> (8*addr[1:0]). LB/LH sign-extend s[7:0]/s[15:0]; LBU/LHU zero-extend; LW uses rdata.
- rd=0 loads still access the bus and pulse `wb_valid` with `wb_rd`=0. The register file discards them.
- Timeout: an 8-bit counter increments each cycle in REQ/WAIT. When it reaches `TIMEOUT_CYCLES` without gnt (REQ) or rvalid (WAIT), drop `mem_req`, pulse exc cause 11 with the stored addr, and go to IDLE. Nothing is written back.
- Reset mid-transaction: abandon on that edge and go to IDLE; `mem_req` is 0 from the next cycle. A late rvalid is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_wstrb`, `wb_valid`, `store_done`, `exc_valid` all 0; `mem_addr`, `mem_wdata`, `wb_rd`, `wb_data`, `exc_cause`, `exc_addr` all 0. `ex_ready`=0 while `rst_n`=0.
- All outputs except `ex_ready` are registered.
- Load, accept at T, zero-wait bus:
  - `mem_req` at T+1.
  - gnt at T+1.
  - rvalid at T+2.
  - `wb_valid` at T+3.
  - `ex_ready` high again at T+3.
- Store, accept at T, gnt at T+1: `store_done` at T+2, `ex_ready` at T+2.
- Exceptions: `exc_valid` at T+1 after accept. `ex_ready` stays high, so back-to-back accepts are legal.
- Each wait cycle on gnt/rvalid adds one cycle. Timeout fires exactly `TIMEOUT_CYCLES` cycles after entering REQ.

## Test plan
- SB addr=0x1003, rs2=0xAABBCCDD, gnt at once → `mem_addr`=0x1000, wstrb=1000, wdata=0xDDDDDDDD, `store_done` at T+2.
- LB addr=0x2001, rdata=0x12348056, rvalid at T+2 → `wb_data`=0x00000080 sign-extended gives 0xFFFFFF80; LBU gives 0x00000080; LHU addr=0x2002 gives 0x00001234.
- LW addr=0x3002 → no `mem_req`; exc cause 01, `exc_addr`=0x3002 at T+1. SH addr=0x3001 → cause 10. funct3=011 load → cause 00.
- LW with gnt delayed 3 cycles and rvalid 2 more → `ex_ready` low throughout; single `wb_valid` at T+7; mem signals stable during REQ.
- `TIMEOUT_CYCLES`=4, no gnt ever → `mem_req` for 4 cycles, then exc cause 11, IDLE, no `wb_valid`.
- `rst_n` low while in WAIT → IDLE next edge; rvalid arriving afterwards gives no `wb_valid`; the following LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: EX->MEM bus handshake, lane alignment,
// load extension and misaligned/illegal/timeout exceptions.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        store_done,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic        accept;
  logic        is_ld;
  logic        is_st;
  logic        ld_ok;
  logic        st_ok;
  logic        illegal;
  logic        misal;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic [8:0]  cnt_nxt;
  logic        tmo;

  assign ex_ready = (state == S_IDLE) && rst_n;
  assign accept   = ex_valid && ex_ready;
  assign is_ld    = ex_mem_read && !ex_mem_write;
  assign is_st    = ex_mem_write && !ex_mem_read;
  assign cnt_nxt  = {1'b0, cnt} + 9'd1;
  assign tmo      = cnt_nxt >= TMO;

  always_comb begin
    ld_ok = 1'b0;
    unique case (ex_funct3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: ld_ok = 1'b1;
      default:        ld_ok = 1'b0;
    endcase
  end

  assign st_ok   = (ex_funct3 == 3'b000) ||
                   (ex_funct3 == 3'b001) ||
                   (ex_funct3 == 3'b010);
  assign illegal = (ex_mem_read && ex_mem_write) ||
                   (is_ld && !ld_ok) ||
                   (is_st && !st_ok);
  assign misal   = (ex_funct3[1:0] == 2'b01 && ex_addr[0]) ||
                   (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);

  always_comb begin
    st_data = ex_wdata;
    st_strb = 4'b1111;
    unique case (1'b1)
      ex_funct3[1:0] == 2'b00: begin
        st_data = {4{ex_wdata[7:0]}};
        st_strb = 4'b0001 << ex_addr[1:0];
      end
      ex_funct3[1:0] == 2'b01: begin
        st_data = {2{ex_wdata[15:0]}};
        st_strb = 4'b0011 << ex_addr[1:0];
      end
      default: begin
        st_data = ex_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = mem_rdata;
    unique case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      addr_q     <= 32'd0;
      rd_q       <= 5'd0;
      f3_q       <= 3'd0;
      we_q       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      store_done <= 1'b0;
      exc_valid  <= 1'b0;
      exc_cause  <= 2'd0;
      exc_addr   <= 32'd0;
    end else begin
      wb_valid   <= 1'b0;
      store_done <= 1'b0;
      exc_valid  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && (ex_mem_read || ex_mem_write)) begin
            if (illegal) begin
              exc_valid <= 1'b1;
              exc_cause <= 2'b00;
              exc_addr  <= ex_addr;
            end else if (misal) begin
              exc_valid <= 1'b1;
              exc_cause <= is_st ? 2'b10 : 2'b01;
              exc_addr  <= ex_addr;
            end else begin
              addr_q    <= ex_addr;
              rd_q      <= ex_rd;
              f3_q      <= ex_funct3;
              we_q      <= is_st;
              cnt       <= 8'd0;
              mem_req   <= 1'b1;
              mem_we    <= is_st;
              mem_addr  <= {ex_addr[31:2], 2'b00};
              mem_wdata <= is_st ? st_data : 32'd0;
              mem_wstrb <= is_st ? st_strb : 4'd0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt_nxt[7:0];
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (we_q) begin
              store_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end else if (tmo) begin
            mem_req   <= 1'b0;
            exc_valid <= 1'b1;
            exc_cause <= 2'b11;
            exc_addr  <= addr_q;
            state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt <= cnt_nxt[7:0];
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ld_data;
            state    <= S_IDLE;
          end else if (tmo) begin
            exc_valid <= 1'b1;
            exc_cause <= 2'b11;
            exc_addr  <= addr_q;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, load extension, exceptions,
// bus wait states, timeout and mid-transaction reset.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  logic        t_valid;
  logic        t_ready;
  logic        t_req;
  logic        t_we;
  logic [31:0] t_maddr;
  logic [31:0] t_mwdata;
  logic [3:0]  t_wstrb;
  logic        t_wb_valid;
  logic [4:0]  t_wb_rd;
  logic [31:0] t_wb_data;
  logic        t_store_done;
  logic        t_exc_valid;
  logic [1:0]  t_exc_cause;
  logic [31:0] t_exc_addr;

  int tests = 0;
  int fails = 0;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .store_done(store_done), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  lsu #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(t_valid), .ex_ready(t_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(t_req), .mem_we(t_we),
    .mem_addr(t_maddr), .mem_wdata(t_mwdata),
    .mem_wstrb(t_wstrb), .mem_gnt(1'b0),
    .mem_rvalid(1'b0), .mem_rdata(32'd0),
    .wb_valid(t_wb_valid), .wb_rd(t_wb_rd), .wb_data(t_wb_data),
    .store_done(t_store_done), .exc_valid(t_exc_valid),
    .exc_cause(t_exc_cause), .exc_addr(t_exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid     = 1'b0;
    t_valid      = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_funct3    = 3'd0;
    ex_addr      = 32'd0;
    ex_wdata     = 32'd0;
    ex_rd        = 5'd0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests++;
    if (ex_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got %b exp 0", ex_ready);
    end
    tests++;
    if ({mem_req, mem_we, mem_wstrb, wb_valid,
         store_done, exc_valid} !== 9'd0) begin
      fails++;
      $display("FAIL rst_ctrl got %b%b%h%b%b%b exp 0",
        mem_req, mem_we, mem_wstrb, wb_valid,
        store_done, exc_valid);
    end
    tests++;
    if ({mem_addr, mem_wdata, wb_rd, wb_data,
         exc_cause, exc_addr} !== 135'd0) begin
      fails++;
      $display("FAIL rst_data got %h %h %h %h %h %h exp 0",
        mem_addr, mem_wdata, wb_rd, wb_data,
        exc_cause, exc_addr);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (ex_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready got %b exp 1", ex_ready);
    end
  endtask

  task automatic test_store_byte;
    ex_valid     = 1'b1;
    ex_mem_write = 1'b1;
    ex_funct3    = 3'b000;
    ex_addr      = 32'h0000_1003;
    ex_wdata     = 32'hAABB_CCDD;
    mem_gnt      = 1'b1;
    tick();
    idle_inputs();
    mem_gnt = 1'b1;
    tests++;
    if ({mem_req, mem_we, mem_wstrb} !== 6'b11_1000) begin
      fails++;
      $display("FAIL sb_req got req=%b we=%b strb=%b exp 1 1 1000",
        mem_req, mem_we, mem_wstrb);
    end
    tests++;
    if (mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hDDDD_DDDD) begin
      fails++;
      $display("FAIL sb_bus got addr=%h wdata=%h exp 00001000 dddddddd",
        mem_addr, mem_wdata);
    end
    tests++;
    if (ex_ready !== 1'b0 || store_done !== 1'b0) begin
      fails++;
      $display("FAIL sb_t1 got ready=%b done=%b exp 0 0",
        ex_ready, store_done);
    end
    tick();
    mem_gnt = 1'b0;
    tests++;
    if (store_done !== 1'b1 || ex_ready !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL sb_t2 got done=%b ready=%b req=%b exp 1 1 0",
        store_done, ex_ready, mem_req);
    end
    tick();
    tests++;
    if (store_done !== 1'b0) begin
      fails++;
      $display("FAIL sb_pulse got %b exp 0", store_done);
    end
  endtask

  task automatic test_store_half;
    ex_valid     = 1'b1;
    ex_mem_write = 1'b1;
    ex_funct3    = 3'b001;
    ex_addr      = 32'h0000_1402;
    ex_wdata     = 32'h1234_5678;
    tick();
    idle_inputs();
    mem_gnt = 1'b1;
    tests++;
    if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'h5678_5678 ||
        mem_addr !== 32'h0000_1400) begin
      fails++;
      $display("FAIL sh_bus got strb=%b wdata=%h addr=%h exp 1100 56785678 00001400",
        mem_wstrb, mem_wdata, mem_addr);
    end
    tick();
    mem_gnt = 1'b0;
    tests++;
    if (store_done !== 1'b1) begin
      fails++;
      $display("FAIL sh_done got %b exp 1", store_done);
    end
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdat, input logic [31:0] exp,
                          input string nm);
    ex_valid    = 1'b1;
    ex_mem_read = 1'b1;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_rd       = 5'd7;
    mem_gnt     = 1'b1;
    tick();
    idle_inputs();
    mem_gnt = 1'b1;
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'd0 ||
        mem_addr !== {a[31:2], 2'b00}) begin
      fails++;
      $display("FAIL %s_req got req=%b we=%b strb=%b addr=%h exp 1 0 0000 %h",
        nm, mem_req, mem_we, mem_wstrb, mem_addr, {a[31:2], 2'b00});
    end
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdat;
    tests++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_t2 got req=%b ready=%b wbv=%b exp 0 0 0",
        nm, mem_req, ex_ready, wb_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== 5'd7 ||
        ex_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_wb got v=%b data=%h rd=%0d ready=%b exp 1 %h 7 1",
        nm, wb_valid, wb_data, wb_rd, ex_ready, exp);
    end
  endtask

  task automatic test_load_ext;
    run_load(3'b000, 32'h0000_2001, 32'h1234_8056, 32'hFFFF_FF80, "lb");
    run_load(3'b100, 32'h0000_2001, 32'h1234_8056, 32'h0000_0080, "lbu");
    run_load(3'b101, 32'h0000_2002, 32'h1234_8056, 32'h0000_1234, "lhu");
    run_load(3'b001, 32'h0000_2000, 32'h1234_8056, 32'hFFFF_8056, "lh");
    run_load(3'b100, 32'h0000_2003, 32'h1234_8056, 32'h0000_0012, "lbu3");
    run_load(3'b010, 32'h0000_2000, 32'h1234_8056, 32'h1234_8056, "lw");
  endtask

  task automatic test_exceptions;
    ex_valid    = 1'b1;
    ex_mem_read = 1'b1;
    ex_funct3   = 3'b010;
    ex_addr     = 32'h0000_3002;
    tick();
    tests++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b01 ||
        exc_addr !== 32'h0000_3002 || mem_req !== 1'b0 ||
        ex_ready !== 1'b1) begin
      fails++;
      $display("FAIL lw_mis got v=%b c=%b a=%h req=%b rdy=%b exp 1 01 00003002 0 1",
        exc_valid, exc_cause, exc_addr, mem_req, ex_ready);
    end
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b1;
    ex_funct3    = 3'b001;
    ex_addr      = 32'h0000_3001;
    tick();
    tests++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b10 ||
        exc_addr !== 32'h0000_3001 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL sh_mis got v=%b c=%b a=%h req=%b exp 1 10 00003001 0",
        exc_valid, exc_cause, exc_addr, mem_req);
    end
    ex_mem_read  = 1'b1;
    ex_mem_write = 1'b0;
    ex_funct3    = 3'b011;
    ex_addr      = 32'h0000_4000;
    tick();
    tests++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b00 ||
        exc_addr !== 32'h0000_4000 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL ld_f3_011 got v=%b c=%b a=%h req=%b exp 1 00 00004000 0",
        exc_valid, exc_cause, exc_addr, mem_req);
    end
    ex_mem_write = 1'b1;
    ex_funct3    = 3'b010;
    ex_addr      = 32'h0000_4444;
    tick();
    tests++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b00 ||
        exc_addr !== 32'h0000_4444 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL rd_and_wr got v=%b c=%b a=%h req=%b exp 1 00 00004444 0",
        exc_valid, exc_cause, exc_addr, mem_req);
    end
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    tick();
    idle_inputs();
    tests++;
    if (exc_valid !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      fails++;
      $display("FAIL nop got exc=%b req=%b rdy=%b exp 0 0 1",
        exc_valid, mem_req, ex_ready);
    end
  endtask

  task automatic test_wait_states;
    int wbs;
    wbs = 0;
    ex_valid    = 1'b1;
    ex_mem_read = 1'b1;
    ex_funct3   = 3'b010;
    ex_addr     = 32'h0000_5000;
    ex_rd       = 5'd3;
    tick();
    idle_inputs();
    for (int c = 1; c <= 8; c++) begin
      mem_gnt    = (c == 4);
      mem_rvalid = (c == 6);
      mem_rdata  = (c == 6) ? 32'hCAFE_BABE : 32'h0;
      if (wb_valid === 1'b1) wbs++;
      tests++;
      if (mem_req !== (c <= 4) || ex_ready !== (c >= 7) ||
          wb_valid !== (c == 7)) begin
        fails++;
        $display("FAIL ws_c%0d got req=%b rdy=%b wbv=%b", c,
          mem_req, ex_ready, wb_valid);
      end
      if (c <= 4) begin
        tests++;
        if (mem_addr !== 32'h0000_5000 || mem_we !== 1'b0 ||
            mem_wstrb !== 4'd0) begin
          fails++;
          $display("FAIL ws_stable_c%0d got addr=%h we=%b strb=%b exp 00005000 0 0",
            c, mem_addr, mem_we, mem_wstrb);
        end
      end
      if (c == 7) begin
        tests++;
        if (wb_data !== 32'hCAFE_BABE || wb_rd !== 5'd3) begin
          fails++;
          $display("FAIL ws_wb got data=%h rd=%0d exp cafebabe 3",
            wb_data, wb_rd);
        end
      end
      tick();
    end
    idle_inputs();
    tests++;
    if (wbs !== 1) begin
      fails++;
      $display("FAIL ws_count got %0d exp 1", wbs);
    end
  endtask

  task automatic test_timeout;
    t_valid     = 1'b1;
    ex_mem_read = 1'b1;
    ex_funct3   = 3'b010;
    ex_addr     = 32'h0000_6004;
    tick();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      tests++;
      if (t_req !== (c <= 4) || t_exc_valid !== (c == 5) ||
          t_wb_valid !== 1'b0 || t_ready !== (c >= 5)) begin
        fails++;
        $display("FAIL to_c%0d got req=%b exc=%b wbv=%b rdy=%b", c,
          t_req, t_exc_valid, t_wb_valid, t_ready);
      end
      if (c == 5) begin
        tests++;
        if (t_exc_cause !== 2'b11 || t_exc_addr !== 32'h0000_6004) begin
          fails++;
          $display("FAIL to_cause got c=%b a=%h exp 11 00006004",
            t_exc_cause, t_exc_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    ex_valid    = 1'b1;
    ex_mem_read = 1'b1;
    ex_funct3   = 3'b010;
    ex_addr     = 32'h0000_7000;
    ex_rd       = 5'd9;
    mem_gnt     = 1'b1;
    tick();
    idle_inputs();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    tests++;
    if (ex_ready !== 1'b0) begin
      fails++;
      $display("FAIL rm_ready_low got %b exp 0", ex_ready);
    end
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_DEAD;
    #1;
    tests++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL rm_idle got req=%b rdy=%b wbv=%b exp 0 1 0",
        mem_req, ex_ready, wb_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL rm_late_rvalid got %b exp 0", wb_valid);
    end
    run_load(3'b010, 32'h0000_7004, 32'h1122_3344, 32'h1122_3344, "rm_lw");
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_load_ext();
    test_exceptions();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
